// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared activation types and helpers for the CIM datapath
//
// Purpose : activation word type, unsigned max helper and the frame FSM
//           state encoding used by the pooling stage.
// Ports   : none (package).
package cim_pkg;

  localparam int unsigned data_w = 8;

  typedef logic [data_w-1:0] data_t;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_RUN  = 1'b1
  } frame_state_t;

  // Unsigned maximum over the full activation width.
  function automatic data_t umax(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - per-channel line buffer of partial window maxima
//
// Purpose : channels x out_width simple dual-port RAM. Synchronous write,
//           combinational read, so the pooling stage sees the stored partial
//           maximum in the same cycle it presents the address.
// Ports   : clk                      clock
//           wr_en, wr_ch, wr_k       write strobe and address (channel, window column)
//           wr_data                  partial window maximum to store
//           rd_ch, rd_k              read address (channel, window column)
//           rd_data                  stored partial window maximum
module pool_line_buf
  import cim_pkg::*;
#(
  parameter int channels  = 5,
  parameter int out_width = 12,
  parameter int ch_w      = 3,
  parameter int k_w       = 5
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ch_w-1:0] wr_ch,
  input  logic [k_w-1:0]  wr_k,
  input  data_t           wr_data,
  input  logic [ch_w-1:0] rd_ch,
  input  logic [k_w-1:0]  rd_k,
  output data_t           rd_data
);

  localparam int depth  = channels * out_width;
  localparam int addr_w = (depth > 1) ? $clog2(depth) : 1;

  data_t             mem [depth];
  logic [addr_w-1:0] wr_addr;
  logic [addr_w-1:0] rd_addr;

  // Channel-major layout: each channel owns a contiguous out_width slice.
  assign wr_addr = addr_w'(wr_ch) * addr_w'(out_width) + addr_w'(wr_k);
  assign rd_addr = addr_w'(rd_ch) * addr_w'(out_width) + addr_w'(rd_k);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reads outside the pooled region (truncated columns) return don't-care
  // data; the caller never uses it there.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_layer.sv
// rtl/max_pool_layer.sv - streaming PxP max-pooling stage feeding next-layer ibufs
//
// Purpose : consumes one activation per cycle in raster order (pixel-major,
//           channel-minor) and writes each pooled maximum to its channel's
//           input-buffer port one cycle after the window's last sample.
//           Rows/columns beyond out_width*pool_dim are consumed and dropped.
// Ports   : clk, rst          clock, synchronous active-high reset
//           i_frame_start     next valid sample is pixel (0,0) channel 0
//           i_valid, i_data   activation stream
//           o_ibuf_we         one-hot write strobe per channel
//           o_ibuf_wr_data    pooled value per channel (held between strobes)
//           o_busy            frame in progress
//           o_frame_done      one-cycle pulse after the frame's last sample
module max_pool_layer
  import cim_pkg::*;
#(
  parameter int channels      = 5,
  parameter int img_width     = 24,
  parameter int pool_dim      = 2,
  parameter int datatype_size = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_frame_start,
  input  logic                                    i_valid,
  input  logic [datatype_size-1:0]                i_data,
  output logic [channels-1:0]                     o_ibuf_we,
  output logic [channels-1:0][datatype_size-1:0]  o_ibuf_wr_data,
  output logic                                    o_busy,
  output logic                                    o_frame_done
);

  localparam int out_width = img_width / pool_dim;
  localparam int ch_w      = (channels > 1) ? $clog2(channels) : 1;
  localparam int x_w       = $clog2(img_width + 1);
  localparam int p_w       = (pool_dim > 1) ? $clog2(pool_dim) : 1;

  localparam logic [ch_w-1:0] ch_last = ch_w'(channels - 1);
  localparam logic [x_w-1:0]  x_last  = x_w'(img_width - 1);
  localparam logic [x_w-1:0]  x_limit = x_w'(out_width * pool_dim);
  localparam logic [p_w-1:0]  p_last  = p_w'(pool_dim - 1);

  // The line buffer is read at wc==0 and written at wc==P-1; with P==1 those
  // collide on the same address in the same cycle.
  if (pool_dim < 2) begin : g_bad_pool_dim
    $error("max_pool_layer: pool_dim must be at least 2");
  end
  if (datatype_size != data_w) begin : g_bad_data_width
    $error("max_pool_layer: datatype_size must match cim_pkg::data_w");
  end

  // Registered position counters. wc/wr/k track col%P, row%P and col/P
  // incrementally so no divider is needed.
  logic [ch_w-1:0] ch_q;
  logic [x_w-1:0]  col_q, row_q, k_q;
  logic [p_w-1:0]  wc_q, wr_q;

  // Effective position of the current sample: i_frame_start rewinds to (0,0,0).
  logic [ch_w-1:0] ch;
  logic [x_w-1:0]  col, row, k;
  logic [p_w-1:0]  wc, wr;

  logic [ch_w-1:0] ch_n;
  logic [x_w-1:0]  col_n, row_n, k_n;
  logic [p_w-1:0]  wc_n, wr_n;

  data_t        acc [channels];
  data_t        lb_rd;
  data_t        cand_acc;
  data_t        cand_lb;
  data_t        acc_n;
  logic         in_win;
  logic         lb_we;
  logic         emit;
  logic         frame_last;
  frame_state_t state;

  assign ch  = i_frame_start ? '0 : ch_q;
  assign col = i_frame_start ? '0 : col_q;
  assign row = i_frame_start ? '0 : row_q;
  assign k   = i_frame_start ? '0 : k_q;
  assign wc  = i_frame_start ? '0 : wc_q;
  assign wr  = i_frame_start ? '0 : wr_q;

  assign in_win   = (col < x_limit) && (row < x_limit);
  assign cand_acc = umax(i_data, acc[ch]);
  assign cand_lb  = umax(i_data, lb_rd);

  // First column of a window row restarts from the data (top row) or from
  // the partial maximum left in the line buffer by the rows above.
  assign acc_n = (wc != '0) ? cand_acc : ((wr == '0) ? i_data : cand_lb);

  assign lb_we      = i_valid && in_win && (wc == p_last) && (wr != p_last);
  assign emit       = i_valid && in_win && (wc == p_last) && (wr == p_last);
  assign frame_last = i_valid && (ch == ch_last) && (col == x_last) && (row == x_last);

  always_comb begin
    ch_n  = ch;
    col_n = col;
    row_n = row;
    wc_n  = wc;
    wr_n  = wr;
    k_n   = k;
    if (ch != ch_last) begin
      ch_n = ch + 1'b1;
    end else begin
      ch_n = '0;
      if (col != x_last) begin
        col_n = col + 1'b1;
        if (wc == p_last) begin
          wc_n = '0;
          k_n  = k + 1'b1;
        end else begin
          wc_n = wc + 1'b1;
        end
      end else begin
        col_n = '0;
        wc_n  = '0;
        k_n   = '0;
        if (row != x_last) begin
          row_n = row + 1'b1;
          wr_n  = (wr == p_last) ? '0 : wr + 1'b1;
        end else begin
          row_n = '0;
          wr_n  = '0;
        end
      end
    end
  end

  pool_line_buf #(
    .channels  (channels),
    .out_width (out_width),
    .ch_w      (ch_w),
    .k_w       (x_w)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_ch   (ch),
    .wr_k    (k),
    .wr_data (cand_acc),
    .rd_ch   (ch),
    .rd_k    (k),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
      k_q   <= '0;
      wc_q  <= '0;
      wr_q  <= '0;
      for (int c = 0; c < channels; c++) begin
        acc[c] <= '0;
      end
    end else if (i_valid) begin
      ch_q  <= ch_n;
      col_q <= col_n;
      row_q <= row_n;
      k_q   <= k_n;
      wc_q  <= wc_n;
      wr_q  <= wr_n;
      if (in_win) begin
        acc[ch] <= acc_n;
      end
    end else if (i_frame_start) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
      k_q   <= '0;
      wc_q  <= '0;
      wr_q  <= '0;
    end
  end

  // Emit stage: one strobe per window end; other channels keep their data.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ibuf_we      <= '0;
      o_ibuf_wr_data <= '0;
    end else begin
      o_ibuf_we <= '0;
      if (emit) begin
        o_ibuf_we[ch]      <= 1'b1;
        o_ibuf_wr_data[ch] <= cand_acc;
      end
    end
  end

  // Frame FSM. A lone i_frame_start abandons the frame; one paired with a
  // valid sample starts a new frame immediately, so the FSM stays in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FRAME_IDLE;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= frame_last;
      case (state)
        FRAME_IDLE: begin
          if (i_valid && !frame_last) begin
            state  <= FRAME_RUN;
            o_busy <= 1'b1;
          end
        end
        FRAME_RUN: begin
          if (frame_last || (i_frame_start && !i_valid)) begin
            state  <= FRAME_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= FRAME_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool_layer.sv
// tb/tb_max_pool_layer.sv - self-checking bench for max_pool_layer
module tb_max_pool_layer;

  localparam int C  = 3;
  localparam int W  = 5;
  localparam int P  = 2;
  localparam int OW = W / P;
  localparam int N  = W * W * C;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_frame_start;
  logic                i_valid;
  logic [7:0]          i_data;
  logic [C-1:0]        o_ibuf_we;
  logic [C-1:0][7:0]   o_ibuf_wr_data;
  logic                o_busy;
  logic                o_frame_done;

  always #5 clk = ~clk;

  max_pool_layer #(
    .channels      (C),
    .img_width     (W),
    .pool_dim      (P),
    .datatype_size (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_frame_start  (i_frame_start),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ibuf_we      (o_ibuf_we),
    .o_ibuf_wr_data (o_ibuf_wr_data),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done)
  );

  int   checks = 0;
  int   errors = 0;
  int   frame_mem [N];
  int   obs_ch[$];
  int   obs_val[$];
  int   exp_ch[$];
  int   exp_val[$];
  int   done_cnt = 0;
  int   busy_cnt = 0;
  logic valid_d = 1'b0;
  logic [7:0] held [C];

  always @(posedge clk) valid_d <= i_valid;

  // Output monitor: collects strobes, enforces one-hot, strobe-after-valid
  // and data hold on non-strobed channels.
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < C; c++) held[c] = 8'h00;
    end else begin
      if (o_ibuf_we != '0) begin
        checks++;
        if (!$onehot(o_ibuf_we)) begin
          errors++;
          $display("FAIL strobe_onehot got %b want one bit", o_ibuf_we);
        end
        checks++;
        if (valid_d !== 1'b1) begin
          errors++;
          $display("FAIL strobe_after_valid got valid_d=%b want 1", valid_d);
        end
      end
      checks++;
      for (int c = 0; c < C; c++) begin
        if (o_ibuf_we[c]) begin
          obs_ch.push_back(c);
          obs_val.push_back(int'(o_ibuf_wr_data[c]));
          held[c] = o_ibuf_wr_data[c];
        end else if (o_ibuf_wr_data[c] !== held[c]) begin
          errors++;
          $display("FAIL data_hold ch%0d got %0d want %0d", c, o_ibuf_wr_data[c], held[c]);
        end
      end
      if (o_frame_done) done_cnt++;
      if (o_busy) busy_cnt++;
    end
  end

  // Reference model: max over each complete PxP window, emitted in the order
  // the window-end samples arrive (window row, window column, channel).
  function automatic void build_expected();
    int m;
    exp_ch.delete();
    exp_val.delete();
    for (int wy = 0; wy < OW; wy++)
      for (int wx = 0; wx < OW; wx++)
        for (int c = 0; c < C; c++) begin
          m = 0;
          for (int dy = 0; dy < P; dy++)
            for (int dx = 0; dx < P; dx++)
              if (frame_mem[((wy*P + dy)*W + (wx*P + dx))*C + c] > m)
                m = frame_mem[((wy*P + dy)*W + (wx*P + dx))*C + c];
          exp_ch.push_back(c);
          exp_val.push_back(m);
        end
  endfunction

  function automatic void fill_random(input bit extremes);
    int r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 3);
      if (extremes && r == 0)      frame_mem[i] = 0;
      else if (extremes && r == 1) frame_mem[i] = 255;
      else                         frame_mem[i] = $urandom_range(0, 255);
    end
  endfunction

  function automatic void fill_pattern();
    for (int p = 0; p < W*W; p++)
      for (int c = 0; c < C; c++) frame_mem[p*C + c] = 10*c + p;
  endfunction

  function automatic void clear_obs();
    obs_ch.delete();
    obs_val.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endfunction

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_frame_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int first, input int last, input bit gaps, input bit fs_first);
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        i_valid = 1'b0;
        i_frame_start = 1'b0;
        i_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
      i_valid = 1'b1;
      i_data = 8'(frame_mem[i]);
      i_frame_start = fs_first && (i == first);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    i_frame_start = 1'b0;
    i_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_ibuf_we !== '0) begin errors++; $display("FAIL reset_we got %b want 0", o_ibuf_we); end
    checks++; if (o_ibuf_wr_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", o_ibuf_wr_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_frame_done); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    int ramp_exp [12] = '{18, 19, 20, 24, 25, 26, 48, 49, 50, 54, 55, 56};
    for (int i = 0; i < N; i++) frame_mem[i] = i;
    clear_obs();
    drive(0, N-1, 1'b0, 1'b0);
    idle(3);
    checks++;
    if (obs_val.size() != 12) begin errors++; $display("FAIL ramp_count got %0d want 12", obs_val.size()); end
    for (int i = 0; i < 12 && i < obs_val.size(); i++) begin
      checks++;
      if (obs_ch[i] != i % C || obs_val[i] != ramp_exp[i]) begin
        errors++;
        $display("FAIL ramp_emit[%0d] got ch%0d=%0d want ch%0d=%0d", i, obs_ch[i], obs_val[i], i % C, ramp_exp[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ramp_done got %0d want 1", done_cnt); end
    checks++; if (busy_cnt != N-1) begin errors++; $display("FAIL ramp_busy_cycles got %0d want %0d", busy_cnt, N-1); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end got %b want 0", o_busy); end
  endtask

  task automatic test_frame(input string name, input int kind, input bit gaps);
    if (kind == 0) fill_pattern();
    else fill_random(kind == 2);
    build_expected();
    clear_obs();
    drive(0, N-1, gaps, 1'b0);
    idle(3);
    checks++;
    if (obs_val.size() != exp_val.size()) begin
      errors++; $display("FAIL %s_count got %0d want %0d", name, obs_val.size(), exp_val.size());
    end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      checks++;
      if (obs_ch[i] != exp_ch[i] || obs_val[i] != exp_val[i]) begin
        errors++;
        $display("FAIL %s_emit[%0d] got ch%0d=%0d want ch%0d=%0d", name, i, obs_ch[i], obs_val[i], exp_ch[i], exp_val[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done got %0d want 1", name, done_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b want 0", name, o_busy); end
  endtask

  task automatic test_frame_start();
    fill_random(1'b0);
    clear_obs();
    drive(0, 17, 1'b0, 1'b0);
    i_frame_start = 1'b1;
    @(posedge clk);
    #1;
    i_frame_start = 1'b0;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL fs_busy_cleared got %b want 0", o_busy); end
    @(posedge clk);
    #1;
    drive(0, 17, 1'b0, 1'b0);
    checks++; if (obs_val.size() != 0) begin errors++; $display("FAIL fs_partial_emits got %0d want 0", obs_val.size()); end
    fill_random(1'b0);
    build_expected();
    drive(0, N-1, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (obs_val.size() != exp_val.size()) begin
      errors++; $display("FAIL fs_count got %0d want %0d", obs_val.size(), exp_val.size());
    end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      checks++;
      if (obs_ch[i] != exp_ch[i] || obs_val[i] != exp_val[i]) begin
        errors++;
        $display("FAIL fs_emit[%0d] got ch%0d=%0d want ch%0d=%0d", i, obs_ch[i], obs_val[i], exp_ch[i], exp_val[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL fs_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    fill_random(1'b0);
    clear_obs();
    drive(0, 20, 1'b0, 1'b0);
    checks++; if (obs_val.size() != 2) begin errors++; $display("FAIL rstmid_pre_emits got %0d want 2", obs_val.size()); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (o_ibuf_we !== '0) begin errors++; $display("FAIL rstmid_we got %b want 0", o_ibuf_we); end
    checks++; if (o_ibuf_wr_data !== '0) begin errors++; $display("FAIL rstmid_data got %h want 0", o_ibuf_wr_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", o_frame_done); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_random(1'b0);
    build_expected();
    clear_obs();
    drive(0, N-1, 1'b0, 1'b0);
    idle(3);
    checks++;
    if (obs_val.size() != exp_val.size()) begin
      errors++; $display("FAIL rstmid_count got %0d want %0d", obs_val.size(), exp_val.size());
    end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      checks++;
      if (obs_ch[i] != exp_ch[i] || obs_val[i] != exp_val[i]) begin
        errors++;
        $display("FAIL rstmid_emit[%0d] got ch%0d=%0d want ch%0d=%0d", i, obs_ch[i], obs_val[i], exp_ch[i], exp_val[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done_cnt got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_frame("pattern", 0, 1'b0);
    test_frame("pattern_gaps", 0, 1'b1);
    test_frame("extremes", 2, 1'b0);
    for (int r = 0; r < 4; r++) test_frame("random_gaps", 1, 1'b1);
    test_frame_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
